// File: rtl/aurora_link_pkg.sv
// ============================================================================
// Module : aurora_link_pkg
// Brief  : Shared types, widths and timing helpers for the Aurora link
//          recovery controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aurora_link_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_RESET    = 3'd1,
    ST_WAIT_UP  = 3'd2,
    ST_UP       = 3'd3,
    ST_DEBOUNCE = 3'd4,
    ST_FAILED   = 3'd5
  } state_t;

  localparam int RETRY_W = 4;
  localparam int DROP_W  = 16;

  // ceil(s * f); the small tolerance absorbs representation error in values like 2e-6
  function automatic longint cycles_from_time(input real s, input real mhz);
    real    x;
    longint c;
    x = s * mhz * 1.0e6;
    c = longint'(x);
    if (real'(c) < x - 1.0e-6) c = c + 1;
    return c;
  endfunction

  function automatic longint max_cycles(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aurora_link_timer.sv
// ============================================================================
// Module : aurora_link_timer
// Brief  : Clearable saturating up-counter; expired_o is high once the count
//          has reached limit_i.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aurora_link_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      count_q <= '0;
    end else if (count_q != {W{1'b1}}) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expired_o = (count_q >= limit_i);

endmodule

`default_nettype wire

// File: rtl/aurora_link_recovery_ctrl.sv
// ============================================================================
// Module : aurora_link_recovery_ctrl
// Brief  : Supervises one Aurora link: reset pulses, link-up wait, drop
//          debounce and bounded retries. Optional exponential backoff of the
//          link-up timeout via `AURORA_LINK_RECOVERY_BACKOFF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aurora_link_recovery_ctrl
  import aurora_link_pkg::*;
#(
  parameter int  SIMULATION           = 0,
  parameter real INIT_CLK_FREQ_MHZ    = 100.0,
  parameter int  LINK_UP_TIMEOUT_MS   = 2000,
  parameter int  RESET_PULSE_CYCLES   = 16,
  parameter int  DOWN_DEBOUNCE_CYCLES = 8,
  parameter int  MAX_RETRIES          = 3
) (
  input  logic               init_clk,
  input  logic               init_rst,
  input  logic               enable,
  input  logic               retry_req,
  input  logic               channel_up,
  output logic               sw_reset,
  output logic               link_up,
  output logic               link_failed,
  output logic [RETRY_W-1:0] retry_count,
  output logic [DROP_W-1:0]  drop_count,
  output logic [2:0]         state
);

  localparam real    C_TIMEOUT_S = (SIMULATION != 0) ? 2.0e-6 : real'(LINK_UP_TIMEOUT_MS) * 1.0e-3;
  localparam longint C_BASE_CYC  = cycles_from_time(C_TIMEOUT_S, INIT_CLK_FREQ_MHZ);
`ifdef AURORA_LINK_RECOVERY_BACKOFF_EN
  localparam longint C_WAIT_MAX  = C_BASE_CYC << 3;
`else
  localparam longint C_WAIT_MAX  = C_BASE_CYC;
`endif
  localparam longint C_MAX_CYC   = max_cycles(C_WAIT_MAX,
                                     max_cycles(longint'(RESET_PULSE_CYCLES),
                                                longint'(DOWN_DEBOUNCE_CYCLES)));
  localparam int     TW          = $clog2(C_MAX_CYC + 1);

  localparam logic [TW-1:0]      C_BASE      = TW'(C_BASE_CYC);
  localparam logic [TW-1:0]      C_RESET_LIM = TW'(RESET_PULSE_CYCLES - 1);
  // The zero that moves ST_UP into ST_DEBOUNCE is the first of the consecutive zeros
  localparam logic [TW-1:0]      C_DEB_LIM   = (DOWN_DEBOUNCE_CYCLES >= 2) ?
                                               TW'(DOWN_DEBOUNCE_CYCLES - 2) : '0;
  localparam logic [RETRY_W-1:0] C_RC_LAST   = RETRY_W'(MAX_RETRIES - 1);
  localparam logic [RETRY_W-1:0] C_RC_MAX    = RETRY_W'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [RETRY_W-1:0] retry_count_q, retry_count_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;
  logic               sw_reset_q, link_up_q, link_failed_q;
  logic               w_restart, w_tmr_clear, w_tmr_exp;
  logic [TW-1:0]      w_wait_lim, w_tmr_lim;

`ifdef AURORA_LINK_RECOVERY_BACKOFF_EN
  logic [1:0] w_shift;
  always_comb begin
    w_shift    = (retry_count_q > RETRY_W'(3)) ? 2'd3 : retry_count_q[1:0];
    w_wait_lim = (C_BASE << w_shift) - TW'(1);
  end
`else
  always_comb begin
    w_wait_lim = C_BASE - TW'(1);
  end
`endif

  always_comb begin
    case (state_q)
      ST_RESET:    w_tmr_lim = C_RESET_LIM;
      ST_WAIT_UP:  w_tmr_lim = w_wait_lim;
      ST_DEBOUNCE: w_tmr_lim = C_DEB_LIM;
      default:     w_tmr_lim = {TW{1'b1}};
    endcase
  end

  aurora_link_timer #(.W(TW)) u_timer (
    .clk       (init_clk),
    .rst       (init_rst),
    .clear_i   (w_tmr_clear),
    .limit_i   (w_tmr_lim),
    .expired_o (w_tmr_exp)
  );

  always_comb begin
    state_d       = state_q;
    retry_count_d = retry_count_q;
    drop_count_d  = drop_count_q;
    w_restart     = 1'b0;
    if (!enable) begin
      state_d = ST_DISABLED;
    end else if (retry_req) begin
      state_d       = ST_RESET;
      retry_count_d = '0;
      w_restart     = 1'b1;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_RESET;
        ST_RESET: begin
          if (w_tmr_exp) state_d = ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (channel_up) begin
            state_d       = ST_UP;
            retry_count_d = '0;
          end else if (w_tmr_exp) begin
            if (retry_count_q == C_RC_LAST) begin
              state_d       = ST_FAILED;
              retry_count_d = C_RC_MAX;
            end else begin
              state_d       = ST_RESET;
              retry_count_d = retry_count_q + RETRY_W'(1);
            end
          end
        end
        ST_UP: begin
          if (!channel_up) begin
            if (DOWN_DEBOUNCE_CYCLES < 2) begin
              state_d = ST_RESET;
              if (drop_count_q != {DROP_W{1'b1}}) drop_count_d = drop_count_q + DROP_W'(1);
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (channel_up) begin
            state_d = ST_UP;
          end else if (w_tmr_exp) begin
            state_d = ST_RESET;
            if (drop_count_q != {DROP_W{1'b1}}) drop_count_d = drop_count_q + DROP_W'(1);
          end
        end
        ST_FAILED: state_d = ST_FAILED;
        default:   state_d = ST_DISABLED;
      endcase
    end
  end

  // A retry request restarts the reset pulse even when already in ST_RESET
  assign w_tmr_clear = (state_d != state_q) || w_restart;

  always_ff @(posedge init_clk) begin
    if (init_rst) begin
      state_q       <= ST_DISABLED;
      retry_count_q <= '0;
      drop_count_q  <= '0;
      sw_reset_q    <= 1'b1;
      link_up_q     <= 1'b0;
      link_failed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_count_q <= retry_count_d;
      drop_count_q  <= drop_count_d;
      sw_reset_q    <= (state_d == ST_DISABLED) || (state_d == ST_RESET) || (state_d == ST_FAILED);
      link_up_q     <= (state_d == ST_UP) || (state_d == ST_DEBOUNCE);
      link_failed_q <= (state_d == ST_FAILED);
    end
  end

  assign sw_reset    = sw_reset_q;
  assign link_up     = link_up_q;
  assign link_failed = link_failed_q;
  assign retry_count = retry_count_q;
  assign drop_count  = drop_count_q;
  assign state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_aurora_link_recovery_ctrl.sv
// ============================================================================
// Module : tb_aurora_link_recovery_ctrl
// Brief  : Directed-with-random-timing checks of the link recovery controller
//          (SIMULATION=1, 100 MHz, so the link-up timeout is 200 cycles).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aurora_link_recovery_ctrl;

  localparam int P    = 16;
  localparam int D    = 8;
  localparam int MAXR = 3;
  localparam int T    = 200;

  localparam logic [2:0] S_DIS  = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_UP   = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd5;

  logic        clk = 1'b0;
  logic        rst, en, rr, cu;
  logic        sw_reset, link_up, link_failed;
  logic [3:0]  retry_count;
  logic [15:0] drop_count;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;
  int drops_exp = 0;

  always #5 clk = ~clk;

  aurora_link_recovery_ctrl #(
    .SIMULATION           (1),
    .INIT_CLK_FREQ_MHZ    (100.0),
    .LINK_UP_TIMEOUT_MS   (2000),
    .RESET_PULSE_CYCLES   (P),
    .DOWN_DEBOUNCE_CYCLES (D),
    .MAX_RETRIES          (MAXR)
  ) dut (
    .init_clk    (clk),
    .init_rst    (rst),
    .enable      (en),
    .retry_req   (rr),
    .channel_up  (cu),
    .sw_reset    (sw_reset),
    .link_up     (link_up),
    .link_failed (link_failed),
    .retry_count (retry_count),
    .drop_count  (drop_count),
    .state       (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Length of the run of sw_reset==lvl starting at the current sample
  task automatic run_len(input logic lvl, input int bound, output int n);
    n = 0;
    while (sw_reset === lvl && n < bound) begin
      n++;
      step();
    end
  endtask

  function automatic int gap_exp(input int a);
`ifdef AURORA_LINK_RECOVERY_BACKOFF_EN
    return T << ((a > 3) ? 3 : a);
`else
    return T + 0 * a;
`endif
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_DIS));
    chk({tag, "_swrst"}, 32'(sw_reset), 32'd1);
    chk({tag, "_lup"},   32'(link_up), 32'd0);
    chk({tag, "_lfail"}, 32'(link_failed), 32'd0);
    chk({tag, "_rc"},    32'(retry_count), 32'd0);
    chk({tag, "_drop"},  32'(drop_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d, g;
    logic ok;
    rst = 1'b1; en = 1'b0; rr = 1'b0; cu = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();
    chk("dis_hold", 32'(state), 32'(S_DIS));

    // Bring-up with channel_up after a random wait shorter than the timeout
    en = 1'b1;
    step();
    chk("en_state", 32'(state), 32'(S_RST));
    run_len(1'b1, 100, n);
    chk("pulse_first", n, P);
    chk("wait_state", 32'(state), 32'(S_WAIT));
    d = $urandom_range(5, 150);
    repeat (d) step();
    cu = 1'b1;
    step();
    chk("up_state", 32'(state), 32'(S_UP));
    chk("up_lup", 32'(link_up), 32'd1);
    chk("up_rc", 32'(retry_count), 32'd0);
    chk("up_swrst", 32'(sw_reset), 32'd0);

    // Glitches below the debounce length, then a real drop
    for (int r = 0; r < 3; r++) begin
      g = $urandom_range(1, D - 1);
      cu = 1'b0;
      ok = 1'b1;
      repeat (g) begin
        step();
        if (link_up !== 1'b1) ok = 1'b0;
      end
      cu = 1'b1;
      step();
      chk("glitch_lup", 32'(ok), 32'd1);
      chk("glitch_state", 32'(state), 32'(S_UP));
      chk("glitch_drop", 32'(drop_count), drops_exp);
      cu = 1'b0;
      repeat (D - 1) step();
      chk("predrop_lup", 32'(link_up), 32'd1);
      step();
      drops_exp++;
      chk("drop_state", 32'(state), 32'(S_RST));
      chk("drop_lup", 32'(link_up), 32'd0);
      chk("drop_cnt", 32'(drop_count), drops_exp);
      chk("drop_rc", 32'(retry_count), 32'd0);
      cu = 1'b1;
      run_len(1'b1, 100, n);
      chk("drop_pulse", n, P);
      step();
      chk("relink_state", 32'(state), 32'(S_UP));
    end

    // Link lost for good: drop, then retries until failure
    cu = 1'b0;
    repeat (D) step();
    drops_exp++;
    chk("lost_drop", 32'(drop_count), drops_exp);
    run_len(1'b1, 100, n);
    chk("lost_pulse", n, P);
    for (int a = 0; a < MAXR; a++) begin
      run_len(1'b0, 4000, n);
      chk("retry_gap", n, gap_exp(a));
      if (a < MAXR - 1) begin
        chk("retry_rc", 32'(retry_count), a + 1);
        run_len(1'b1, 100, n);
        chk("retry_pulse", n, P);
      end
    end
    chk("fail_state", 32'(state), 32'(S_FAIL));
    chk("fail_flag", 32'(link_failed), 32'd1);
    chk("fail_rc", 32'(retry_count), MAXR);
    chk("fail_lup", 32'(link_up), 32'd0);
    repeat (50) step();
    chk("fail_hold_state", 32'(state), 32'(S_FAIL));
    chk("fail_hold_swrst", 32'(sw_reset), 32'd1);

    // Software retry out of failure, then disable mid-wait
    rr = 1'b1;
    step();
    rr = 1'b0;
    chk("rr_state", 32'(state), 32'(S_RST));
    chk("rr_rc", 32'(retry_count), 32'd0);
    chk("rr_lfail", 32'(link_failed), 32'd0);
    run_len(1'b1, 100, n);
    chk("rr_pulse", n, P);
    chk("rr_wait", 32'(state), 32'(S_WAIT));
    repeat ($urandom_range(3, 100)) step();
    en = 1'b0;
    step();
    chk("dis_state", 32'(state), 32'(S_DIS));
    chk("dis_swrst", 32'(sw_reset), 32'd1);

    // Reset while the link is up
    en = 1'b1;
    cu = 1'b1;
    n = 0;
    while (link_up !== 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("rst_pre_lup", 32'(link_up), 32'd1);
    chk("rst_pre_drop", 32'(drop_count), drops_exp);
    rst = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0;
    en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
